mux2_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 mux datapath between two requesters. It owns the mux select line and issues per-requester grants. Each grant holds for a bounded burst. The selected data is registered onto a single output channel. The block sits in front of MUX_2_1, with in1 taken from requester 0 and in2 from requester 1, and drives its sel.

---
 rtl/mux2_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux that grants bounded bursts and registers the selected beat.
// Accepted beat appears on out_data/out_valid 1 cycle later; requesters stall by holding req until granted.
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last1_q, last1_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                accept;
  logic                entry;
  logic [DATA_W-1:0]   mux_dat;

  // The shared datapath: sel=1 routes in1 (requester 0), sel=0 routes in2 (requester 1).
  assign mux_dat = sel_q ? data0 : data1;
  assign accept  = ((state_q == G0) && req0) || ((state_q == G1) && req1);

  always_comb begin
    state_d     = state_q;
    entry       = 1'b0;
    cnt_d       = cnt_q;
    last1_d     = last1_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // last1_q means requester 1 was served last, so requester 0 wins a tie.
        if (req0 && (!req1 || last1_q)) begin
          state_d = G0;
          entry   = 1'b1;
        end else if (req1) begin
          state_d = G1;
          entry   = 1'b1;
        end
      end
      G0: begin
        if (!req0) begin
          state_d = req1 ? G1 : IDLE;
          entry   = req1;
        end else if (cnt_q == LAST_BEAT) begin
          state_d = req1 ? G1 : G0;
          entry   = 1'b1;
        end
      end
      G1: begin
        if (!req1) begin
          state_d = req0 ? G0 : IDLE;
          entry   = req0;
        end else if (cnt_q == LAST_BEAT) begin
          state_d = req0 ? G0 : G1;
          entry   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A re-grant to the same owner is still an entry: the burst count restarts.
    if (entry) begin
      cnt_d   = 4'd0;
      last1_d = (state_d == G1);
      sel_d   = (state_d == G0);
    end else if (accept) begin
      cnt_d = 4'(cnt_q + 4'd1);
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
    end

    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last1_q     <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last1_q     <= last1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: one instance with MAX_BURST=4 and one with MAX_BURST=1 share the stimulus.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;

  logic       gnt0_a, gnt1_a, sel_a, ov_a;
  logic [7:0] od_a;
  logic       gnt0_b, gnt1_b, sel_b, ov_b;
  logic [7:0] od_b;

  int n_cmp;
  int n_bad;

  // Reference: owner is -1 (nobody), 0 or 1; beats counts accepted beats in the current grant.
  int         m_own   [2];
  int         m_beats [2];
  int         m_last  [2];
  int         m_burst [2];
  bit         m_sel   [2];
  bit         m_ov    [2];
  logic [7:0] m_od    [2];

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .out_data(od_a), .out_valid(ov_a)
  );

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .out_data(od_b), .out_valid(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i]   = -1;
      m_beats[i] = 0;
      m_last[i]  = 1;
      m_sel[i]   = 1'b1;
      m_ov[i]    = 1'b0;
      m_od[i]    = 8'h00;
    end
  endtask

  task automatic model_step();
    bit         r [2];
    logic [7:0] d [2];
    int         o, nxt;
    bit         acc, fresh;
    r[0] = req0;  r[1] = req1;
    d[0] = data0; d[1] = data1;
    for (int i = 0; i < 2; i++) begin
      o     = m_own[i];
      fresh = 1'b0;
      acc   = (o >= 0) && r[o];
      if (o < 0) begin
        if (r[0] && r[1]) nxt = 1 - m_last[i];
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
        fresh = (nxt >= 0);
      end else if (!r[o]) begin
        nxt   = r[1-o] ? 1 - o : -1;
        fresh = (nxt >= 0);
      end else if (m_beats[i] + 1 == m_burst[i]) begin
        nxt   = r[1-o] ? 1 - o : o;
        fresh = 1'b1;
      end else begin
        nxt        = o;
        m_beats[i] = m_beats[i] + 1;
      end
      m_ov[i] = acc;
      if (acc) m_od[i] = d[o];
      m_own[i] = nxt;
      if (fresh) begin
        m_beats[i] = 0;
        m_last[i]  = nxt;
        m_sel[i]   = (nxt == 0);
      end
    end
  endtask

  task automatic chk_dut(input string p, input int i, input logic g0, input logic g1,
                         input logic s, input logic ov, input logic [7:0] od);
    chk({p, "_gnt0"}, 32'(g0), 32'(m_own[i] == 0));
    chk({p, "_gnt1"}, 32'(g1), 32'(m_own[i] == 1));
    chk({p, "_excl"}, 32'(g0 & g1), 32'd0);
    chk({p, "_sel"}, 32'(s), 32'(m_sel[i]));
    chk({p, "_out_valid"}, 32'(ov), 32'(m_ov[i]));
    chk({p, "_out_data"}, 32'(od), 32'(m_od[i]));
  endtask

  // Check current outputs at the falling edge, then drive the next cycle's inputs.
  task automatic cycle(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    chk_dut("a", 0, gnt0_a, gnt1_a, sel_a, ov_a, od_a);
    chk_dut("b", 1, gnt0_b, gnt1_b, sel_b, ov_b, od_b);
    req0  = r0;
    req1  = r1;
    data0 = d0;
    data1 = d1;
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic r0, r1;
    n_cmp      = 0;
    n_bad      = 0;
    m_burst[0] = 4;
    m_burst[1] = 1;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 32'(gnt0_a), 32'd0);
    chk("rst_gnt1", 32'(gnt1_a), 32'd0);
    chk("rst_sel", 32'(sel_a), 32'd1);
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_out_data", 32'(od_a), 32'd0);
    rst_n = 1'b1;

    // Single requester streaming past the burst limit: re-grant without a gap.
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'(8'h11 + k), 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);

    // Both requesting from reset: 4/4 alternation on dut_a, strict alternation on dut_b.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b1, 8'hA0, 8'hB0);
      if (k >= 1) chk("t2_sel_pattern", 32'(sel_a), 32'((((k - 1) / 4) % 2) == 0));
      if (k >= 2) begin
        chk("t6_valid", 32'(ov_b), 32'd1);
        chk("t6_data", 32'(od_b), ((k - 2) % 2 == 0) ? 32'hA0 : 32'hB0);
      end
    end

    // Owner of G1 drops after 2 beats; grant moves to requester 0 with one idle output cycle.
    do_reset();
    cycle(1'b0, 1'b1, 8'h01, 8'h21);
    chk("t3_g1", 32'(gnt1_a), 32'd0);
    cycle(1'b1, 1'b1, 8'h02, 8'h22);
    chk("t3_g1_owned", 32'(gnt1_a), 32'd1);
    cycle(1'b1, 1'b1, 8'h03, 8'h23);
    cycle(1'b1, 1'b0, 8'h04, 8'h24);
    chk("t3_last_beat_valid", 32'(ov_a), 32'd1);
    cycle(1'b1, 1'b0, 8'h05, 8'h25);
    chk("t3_sel_after_drop", 32'(sel_a), 32'd1);
    chk("t3_gnt0_after_drop", 32'(gnt0_a), 32'd1);
    chk("t3_bubble", 32'(ov_a), 32'd0);
    cycle(1'b1, 1'b1, 8'h06, 8'h26);
    chk("t3_valid_resumes", 32'(ov_a), 32'd1);

    // Everyone goes idle mid-burst, then a tie goes to the requester not last served.
    cycle(1'b0, 1'b0, 8'h07, 8'h27);
    cycle(1'b1, 1'b1, 8'h08, 8'h28);
    chk("t4_idle_gnt0", 32'(gnt0_a), 32'd0);
    chk("t4_idle_gnt1", 32'(gnt1_a), 32'd0);
    chk("t4_idle_sel_held", 32'(sel_a), 32'd1);
    cycle(1'b0, 1'b0, 8'h09, 8'h29);
    chk("t4_tie_winner", 32'(gnt1_a), 32'd1);
    chk("t4_tie_sel", 32'(sel_a), 32'd0);

    // Asynchronous reset in the middle of a G0 burst.
    do_reset();
    cycle(1'b1, 1'b0, 8'h5A, 8'h00);
    cycle(1'b1, 1'b0, 8'h5B, 8'h00);
    cycle(1'b1, 1'b0, 8'h5C, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt0", 32'(gnt0_a), 32'd0);
    chk("t5_async_valid", 32'(ov_a), 32'd0);
    chk("t5_async_data", 32'(od_a), 32'd0);
    chk("t5_async_sel", 32'(sel_a), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 8'h61, 8'h71);
    cycle(1'b1, 1'b1, 8'h62, 8'h72);
    chk("t5_restart_favours_0", 32'(gnt0_a), 32'd1);

    // Random traffic; a requester keeps req high until both instances have granted it.
    for (int n = 0; n < 400; n++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if (req0 && !(m_own[0] == 0 && m_own[1] == 0)) r0 = 1'b1;
      if (req1 && !(m_own[0] == 1 && m_own[1] == 1)) r1 = 1'b1;
      cycle(r0, r1, 8'($urandom), 8'($urandom));
    end
    cycle(1'b0, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
